fifo_burst_arbiter: RTL
=======================

Name: fifo_burst_arbiter

Overview:
Round-robin burst scheduler that drains NUM_CH external fifo_sync instances (e.g. per-stream pixel FIFOs) into one shared downstream burst port (frame-buffer/DRAM write path). A channel is granted only when it holds at least one full burst. The block then requests the downstream port and streams exactly BURST_LEN words from that FIFO. It drives the FIFOs' read strobes and consumes their fill counts and registered read data.

Parameters:
NUM_CH, 4, number of requester FIFOs (2..8)
DATA_WIDTH, 12, word width of each FIFO / output
ADDR_WIDTH, 9, FIFO address width; fill inputs are ADDR_WIDTH+1 bits
BURST_LEN, 8, words per burst; 1 <= BURST_LEN <= 2**ADDR_WIDTH
(localparam CH_W = max(1, clog2(NUM_CH)))

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset
i_enable  in  1  allow new grants; an in-flight burst always completes
i_fill  in  NUM_CH*(ADDR_WIDTH+1)  packed fill counts, channel k at slice k
i_data  in  NUM_CH*DATA_WIDTH  packed FIFO o_data, channel k at slice k
o_rd  out  NUM_CH  one-hot read strobes to the FIFOs' i_rd
o_req  out  1  burst request to downstream
o_chan  out  CH_W  granted channel; stable from grant until the end of DRAIN
i_ack  in  1  downstream accepts the request; sampled only in REQ
o_valid  out  1  output word valid
o_data  out  DATA_WIDTH  output word
o_last  out  1  final word of the burst
o_busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rstn is asynchronous and active-low. Reset clears all state: state=IDLE, o_rd=0, o_req=0, o_valid=0, o_last=0, o_chan=0, o_busy=0, beat counter=0, RR pointer last=NUM_CH-1 so channel 0 has first priority.
- Reset mid-burst aborts immediately and leaves no partial-burst memory. Residual FIFO contents are the owner's concern.
- Eligibility: elig[k] = (i_fill[k] >= BURST_LEN), compared unsigned at full ADDR_WIDTH+1 width.
- FSM states: IDLE, REQ, BURST, DRAIN.
- IDLE: if i_enable and any elig, choose the first eligible channel scanning last+1, last+2, ... modulo NUM_CH. Register it into o_chan and last, then go to REQ. Otherwise stay in IDLE.
- REQ: o_req=1 and o_chan held. On i_ack, deassert o_req and go to BURST. There is no timeout. Eligibility is not re-evaluated in REQ.
- BURST: o_rd[o_chan]=1 for exactly BURST_LEN consecutive cycles, counted by a beat counter 0..BURST_LEN-1. After the last read cycle, go to DRAIN.
- DRAIN: 1 cycle, then IDLE.
- All outputs are registered, except o_data.
- Cycle timing, with i_ack sampled in cycle a:
  - o_rd[o_chan] high in cycles a+1 .. a+BURST_LEN.
  - o_valid high in cycles a+2 .. a+BURST_LEN+1, which is o_rd delayed by one cycle to match fifo_sync's one-cycle registered read.
  - o_last high only in cycle a+BURST_LEN+1, coincident with DRAIN.
  - IDLE is re-entered at a+BURST_LEN+2, and the next grant is registered that cycle at the earliest.
- o_data = combinational mux of the i_data slice selected by o_chan. It is meaningful only while o_valid=1.
- No backpressure inside a burst: downstream must absorb one word per cycle after acking.
- The FIFO fill counts settle before IDLE, so stale-fill re-grants cannot occur.
- i_enable deasserted during REQ/BURST/DRAIN has no effect until IDLE.
- i_ack outside REQ is ignored.
- o_rd is never more than 1-hot and is never asserted outside BURST.
- With a single eligible channel, that channel is re-granted back-to-back.

Decomposition:
- Shared package: the FSM state encoding (IDLE/REQ/BURST/DRAIN) and a clog2 helper function.
- One natural sub-module, rr_pick: combinational round-robin first-eligible selector. Inputs: elig[NUM_CH] and last[CH_W]. Outputs: grant_idx[CH_W] and any_grant. It is reusable by other arbiters in the pipeline.

Test Plan:
- Reset/idle: hold all i_fill=0, i_enable=1 for 50 cycles -> o_busy, o_req, o_rd, o_valid stay 0. Assert i_rstn=0 asynchronously mid-cycle -> outputs clear with no clock edge.
- Single burst: ch2 fill=8, others 0; ack 3 cycles after o_req -> o_chan=2, o_rd=4'b0100 for 8 cycles, o_valid for 8 cycles one cycle later, o_data = FIFO2 words in order, o_last on the 8th word.
- Round-robin: all four fills=64, i_ack tied high -> grant order 0,1,2,3,0,1. Each burst is 8 beats, with exactly 2 non-read cycles (DRAIN+IDLE) plus 1 REQ cycle between bursts.
- Threshold boundary: ch1 fill=7 -> never granted. Raise to 8 -> granted on the next IDLE cycle. ch0 fill=BURST_LEN exactly with ch3 fill=512 (full) -> both served, RR order preserved.
- Enable/ack gating: deassert i_enable during BURST -> current burst completes with 8 beats and no new grant follows. Pulse i_ack while in IDLE -> ignored.
- Reset mid-burst: assert reset at beat 4 -> o_rd and o_valid drop immediately. After release, RR restarts at ch0 regardless of the prior grant.

Source files
------------

// File: rtl/fifo_burst_arbiter_pkg.sv
// Shared types and elaboration helpers for the FIFO burst arbiter and its
// round-robin picker.
package fifo_burst_arbiter_pkg;

    // Scheduler state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int width_of(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/fifo_burst_arbiter_if.sv
// Downstream burst port of the FIFO burst arbiter. Signal names are written
// from the arbiter's point of view: it drives the o_* signals and receives
// i_ack from the burst consumer.
interface fifo_burst_arbiter_if
    import fifo_burst_arbiter_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 12
);
    localparam int CH_W = width_of(NUM_CH);

    logic                  o_req;
    logic                  i_ack;
    logic [CH_W-1:0]       o_chan;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_last;

    modport master (
        output o_req,
        output o_chan,
        output o_valid,
        output o_data,
        output o_last,
        input  i_ack
    );

    modport slave (
        input  o_req,
        input  o_chan,
        input  o_valid,
        input  o_data,
        input  o_last,
        output i_ack
    );

endinterface

// File: rtl/fifo_burst_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first eligible requester
// found scanning last+1, last+2, ... modulo NUM_CH. Kept stand-alone so other
// arbiters in the pipeline can reuse it.
module fifo_burst_arbiter_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] i_elig,
    input  logic [CH_W-1:0]   i_last,
    output logic [CH_W-1:0]   o_grant_idx,
    output logic              o_any_grant
);

    // Walk offsets from farthest to nearest so the nearest eligible hit wins.
    always_comb begin
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        for (int off = NUM_CH; off >= 1; off--) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (i_elig[k] && (k == ((int'(i_last) + off) % NUM_CH))) begin
                    o_grant_idx = CH_W'(k);
                    o_any_grant = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Round-robin burst scheduler. Drains NUM_CH external synchronous FIFOs into a
// single downstream burst port, granting only channels that already hold a
// full burst and then streaming exactly BURST_LEN words from the winner.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for i_enable and an eligible channel; grant is picked
// ST_REQ   | o_req high, o_chan held, waiting for i_ack (no timeout)
// ST_BURST | one read strobe per cycle to the granted FIFO, BURST_LEN beats
// ST_DRAIN | final FIFO word on the port with o_last; back to ST_IDLE
module fifo_burst_arbiter
    import fifo_burst_arbiter_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 9,
    parameter int BURST_LEN  = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rstn,
    input  logic                             i_enable,
    input  logic [NUM_CH*(ADDR_WIDTH+1)-1:0] i_fill,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     i_data,
    output logic [NUM_CH-1:0]                o_rd,
    output logic                             o_busy,
    fifo_burst_arbiter_if.master             bus
);

    localparam int CH_W   = width_of(NUM_CH);
    localparam int FILL_W = ADDR_WIDTH + 1;
    localparam int BEAT_W = width_of(BURST_LEN);

    localparam logic [FILL_W-1:0] C_BURST_FILL = FILL_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] C_LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [CH_W-1:0]   C_PTR_RST    = CH_W'(NUM_CH - 1);

    state_t                r_state;
    state_t                w_nxt_state;

    logic [CH_W-1:0]       r_chan;
    logic [CH_W-1:0]       r_ptr;
    logic [BEAT_W-1:0]     r_beat;
    logic [NUM_CH-1:0]     r_rd;
    logic                  r_req;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_busy;

    logic [CH_W-1:0]       w_nxt_chan;
    logic [CH_W-1:0]       w_nxt_ptr;
    logic [BEAT_W-1:0]     w_nxt_beat;
    logic [NUM_CH-1:0]     w_nxt_rd;
    logic                  w_nxt_req;
    logic                  w_nxt_last;

    logic [NUM_CH-1:0]     w_elig;
    logic [CH_W-1:0]       w_grant_idx;
    logic                  w_any_grant;
    logic [NUM_CH-1:0]     w_chan_onehot;
    logic [DATA_WIDTH-1:0] w_data;

    // A channel is eligible once its FIFO holds at least one whole burst.
    always_comb begin
        w_elig = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_elig[k] = (i_fill[k*FILL_W +: FILL_W] >= C_BURST_FILL);
        end
    end

    fifo_burst_arbiter_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .i_elig      (w_elig),
        .i_last      (r_ptr),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    // One-hot strobe pattern for the currently granted channel.
    always_comb begin
        w_chan_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_chan_onehot[k] = (r_chan == CH_W'(k));
        end
    end

    // Output word comes straight from the granted FIFO's registered read port.
    always_comb begin
        w_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_chan == CH_W'(k)) begin
                w_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and next-output decode for the scheduler.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_chan  = r_chan;
        w_nxt_ptr   = r_ptr;
        w_nxt_beat  = r_beat;
        w_nxt_req   = r_req;
        w_nxt_rd    = '0;
        w_nxt_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && w_any_grant) begin
                    w_nxt_state = ST_REQ;
                    w_nxt_chan  = w_grant_idx;
                    w_nxt_ptr   = w_grant_idx;
                    w_nxt_req   = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.i_ack) begin
                    w_nxt_state = ST_BURST;
                    w_nxt_req   = 1'b0;
                    w_nxt_rd    = w_chan_onehot;
                    w_nxt_beat  = '0;
                end
            end
            ST_BURST: begin
                if (r_beat == C_LAST_BEAT) begin
                    w_nxt_state = ST_DRAIN;
                    w_nxt_last  = 1'b1;
                end else begin
                    w_nxt_rd   = w_chan_onehot;
                    w_nxt_beat = r_beat + 1'b1;
                end
            end
            ST_DRAIN: begin
                w_nxt_state = ST_IDLE;
                w_nxt_beat  = '0;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Scheduler state register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Registered outputs, grant bookkeeping and beat counter; o_valid trails
    // the read strobe by one cycle to line up with the FIFO's registered data.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_chan  <= '0;
            r_ptr   <= C_PTR_RST;
            r_beat  <= '0;
            r_rd    <= '0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_chan  <= w_nxt_chan;
            r_ptr   <= w_nxt_ptr;
            r_beat  <= w_nxt_beat;
            r_rd    <= w_nxt_rd;
            r_req   <= w_nxt_req;
            r_valid <= |r_rd;
            r_last  <= w_nxt_last;
            r_busy  <= (w_nxt_state != ST_IDLE);
        end
    end

    assign o_rd        = r_rd;
    assign o_busy      = r_busy;
    assign bus.o_req   = r_req;
    assign bus.o_chan  = r_chan;
    assign bus.o_valid = r_valid;
    assign bus.o_data  = w_data;
    assign bus.o_last  = r_last;

endmodule
